// File: rtl/count_seq_pkg.sv
// Shared command encoding, FSM state type and helpers for the count sequencer.
package count_seq_pkg;

  localparam logic [3:0] OP_CTRL   = 4'h0;
  localparam logic [3:0] OP_INT    = 4'h1;
  localparam logic [3:0] OP_SETTLE = 4'h2;
  localparam logic [3:0] OP_NPAT   = 4'h3;

  localparam logic [15:0] CMD_STOP  = 16'h0000;
  localparam logic [15:0] CMD_START = 16'h0001;
  localparam logic [15:0] CMD_READ  = 16'h0003;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    SETTLE,
    GATE,
    HOLD,
    LATCH
  } state_t;

  // A zero integration time or pattern count behaves as one.
  function automatic logic [11:0] at_least_one(input logic [11:0] v);
    return (v == 12'd0) ? 12'd1 : v;
  endfunction

endpackage

// File: rtl/count_sequencer_tick_timer.sv
// Interval timer: TICK-cycle prescaler feeding a 12-bit unit down-counter.
module tick_timer #(
  parameter int TICK = 100
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        load,
  input  logic [11:0] units,
  input  logic        clear,
  output logic        expire
);
  localparam int PW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(TICK - 1);

  logic          active_q;
  logic [PW-1:0] pre_q;
  logic [11:0]   unit_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      active_q <= 1'b0;
    end else if (clear) begin
      active_q <= 1'b0;
    end else if (load) begin
      active_q <= 1'b1;
    end else if (active_q && pre_q == '0 && unit_q == '0) begin
      active_q <= 1'b0;
    end
  end

  // Interval covers units*TICK cycles starting the cycle after load.
  always_ff @(posedge CLK) begin
    if (load) begin
      pre_q  <= PRE_TOP;
      unit_q <= units - 12'd1;
    end else if (active_q) begin
      if (pre_q == '0) begin
        pre_q  <= PRE_TOP;
        unit_q <= unit_q - 12'd1;
      end else begin
        pre_q <= pre_q - 1'b1;
      end
    end
  end

  assign expire = active_q && (pre_q == '0) && (unit_q == '0);

endmodule

// File: rtl/count_sequencer.sv
// Per-pattern acquisition sequencer: command decode, config registers,
// trigger/settle/gate/latch FSM and the SPI transmit holding register.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int TICK        = 100,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [15:0]            RX,
  input  logic                   RX_VALID,
  input  logic [COUNT_WIDTH-1:0] COUNT_VAL,
  input  logic                   TX_ACK,
  output logic                   PATTERN_TRIG,
  output logic                   COUNT_CLR,
  output logic                   COUNT_EN,
  output logic [COUNT_WIDTH-1:0] TX_DATA,
  output logic                   TX_VALID,
  output logic [11:0]            PATTERN_IDX,
  output logic                   BUSY,
  output logic                   DONE
);
  state_t      state_q, state_d;
  logic [11:0] int_q, settle_q, npat_q;
  logic        has_result_q;
  logic [3:0]  opcode;
  logic        start_cmd, stop_cmd, read_cmd, cfg_wr;
  logic [11:0] gate_units, timer_units;
  logic        last_pat, timer_load, timer_expire;

  assign opcode     = RX[15:12];
  assign start_cmd  = RX_VALID && (RX == CMD_START);
  assign stop_cmd   = RX_VALID && (RX == CMD_STOP);
  assign read_cmd   = RX_VALID && (RX == CMD_READ);
  assign cfg_wr     = RX_VALID && (state_q == IDLE);
  assign gate_units = at_least_one(int_q);
  assign last_pat   = (PATTERN_IDX == (at_least_one(npat_q) - 12'd1));

  // TRIG arms either the settle or the gate interval; SETTLE expiry re-arms for the gate.
  assign timer_load  = (state_q == TRIG) || ((state_q == SETTLE) && timer_expire);
  assign timer_units = ((state_q == TRIG) && (settle_q != 12'd0)) ? settle_q : gate_units;

  tick_timer #(.TICK(TICK)) u_timer (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .load   (timer_load),
    .units  (timer_units),
    .clear  (stop_cmd),
    .expire (timer_expire)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      int_q    <= 12'd1;
      settle_q <= 12'd0;
      npat_q   <= 12'd1;
    end else if (cfg_wr) begin
      case (opcode)
        OP_INT:    int_q    <= RX[11:0];
        OP_SETTLE: settle_q <= RX[11:0];
        OP_NPAT:   npat_q   <= RX[11:0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_cmd) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_cmd) state_d = TRIG;
        TRIG:    state_d = (settle_q == 12'd0) ? GATE : SETTLE;
        SETTLE:  if (timer_expire) state_d = GATE;
        GATE:    if (timer_expire) state_d = HOLD;
        HOLD:    if (!TX_VALID) state_d = LATCH;
        LATCH:   state_d = last_pat ? IDLE : TRIG;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    PATTERN_TRIG = (state_q == TRIG);
    COUNT_CLR    = (state_q == TRIG);
    COUNT_EN     = (state_q == GATE);
    BUSY         = (state_q != IDLE);
    DONE         = (state_q == LATCH) && last_pat && !stop_cmd;
  end

  // An abort in the LATCH cycle discards the latch and leaves the index where it was.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      PATTERN_IDX  <= 12'd0;
      TX_DATA      <= '0;
      has_result_q <= 1'b0;
    end else if (state_q == IDLE && start_cmd) begin
      PATTERN_IDX  <= 12'd0;
      has_result_q <= 1'b0;
    end else if (state_q == LATCH && !stop_cmd) begin
      TX_DATA      <= COUNT_VAL;
      has_result_q <= 1'b1;
      if (!last_pat) PATTERN_IDX <= PATTERN_IDX + 12'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N)                                      TX_VALID <= 1'b0;
    else if (stop_cmd)                               TX_VALID <= 1'b0;
    else if (state_q == LATCH)                       TX_VALID <= 1'b1;
    else if (read_cmd && !TX_VALID && has_result_q)  TX_VALID <= 1'b1;
    else if (TX_ACK)                                 TX_VALID <= 1'b0;
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with TICK=4 and a +3-per-cycle photon counter model.
module tb_count_sequencer;
  localparam int TICK = 4;
  localparam int CW   = 16;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [15:0]   RX;
  logic          RX_VALID;
  logic [CW-1:0] COUNT_VAL;
  logic          TX_ACK;
  logic          PATTERN_TRIG, COUNT_CLR, COUNT_EN, TX_VALID, BUSY, DONE;
  logic [CW-1:0] TX_DATA;
  logic [11:0]   PATTERN_IDX;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] rx;
    logic [1:0]  va;    // {RX_VALID, TX_ACK}
    logic [4:0]  outs;  // {BUSY, PATTERN_TRIG, COUNT_EN, TX_VALID, DONE}
    logic [11:0] idx;
    logic [16:0] tx;    // bit 16 set: check TX_DATA against tx[15:0]
  } vec_t;

  vec_t tbl [18];

  always #5 CLK = ~CLK;

  count_sequencer #(.TICK(TICK), .COUNT_WIDTH(CW)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .RX           (RX),
    .RX_VALID     (RX_VALID),
    .COUNT_VAL    (COUNT_VAL),
    .TX_ACK       (TX_ACK),
    .PATTERN_TRIG (PATTERN_TRIG),
    .COUNT_CLR    (COUNT_CLR),
    .COUNT_EN     (COUNT_EN),
    .TX_DATA      (TX_DATA),
    .TX_VALID     (TX_VALID),
    .PATTERN_IDX  (PATTERN_IDX),
    .BUSY         (BUSY),
    .DONE         (DONE)
  );

  always @(posedge CLK) begin
    if (!RST_N || COUNT_CLR) COUNT_VAL <= '0;
    else if (COUNT_EN)       COUNT_VAL <= COUNT_VAL + 16'd3;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    RX = w;
    RX_VALID = 1'b1;
    step(1);
    RX_VALID = 1'b0;
    RX = 16'h0000;
  endtask

  task automatic ack1();
    TX_ACK = 1'b1;
    step(1);
    TX_ACK = 1'b0;
  endtask

  // sel 0 waits for COUNT_EN, sel 1 for TX_VALID
  task automatic wait_for(input int sel, input string nm);
    int n = 0;
    while (!(sel == 0 ? COUNT_EN : TX_VALID) && n < 100) begin
      step(1);
      n++;
    end
    chk(nm, int'(n < 100), 1);
  endtask

  // Full 3-pattern run (INT=2, SETTLE=1); first result acked after d1 cycles, others after 2.
  task automatic run_acq(input int d1, input string tag);
    int  cyc, t_trig, t_en, ack_at, t_ack, t_done, ntrig, nres, ndone;
    bit  pen, ptxv;
    cyc = 0; t_trig = 0; t_en = 0; ack_at = -1; t_ack = -1; t_done = -1;
    ntrig = 0; nres = 0; ndone = 0; pen = 1'b0; ptxv = 1'b0;
    RX = 16'h0001; RX_VALID = 1'b1; TX_ACK = 1'b0;
    while (cyc < 400 && (t_done < 0 || cyc < t_done + 6)) begin
      step(1);
      cyc++;
      if (PATTERN_TRIG) begin
        chk($sformatf("%s_trig_idx%0d", tag, ntrig), int'(PATTERN_IDX), ntrig);
        if (d1 > 2 && ntrig == 2) chk($sformatf("%s_trig_after_ack", tag), cyc, t_ack + 3);
        ntrig++;
        t_trig = cyc;
      end
      if (COUNT_EN && !pen) begin
        t_en = cyc;
        chk($sformatf("%s_gate_delay", tag), cyc - t_trig, 1 + 1 * TICK);
      end
      if (!COUNT_EN && pen) chk($sformatf("%s_gate_len", tag), cyc - t_en, 2 * TICK);
      if (TX_VALID && !ptxv) begin
        chk($sformatf("%s_tx_data%0d", tag, nres), int'(TX_DATA), 24);
        ack_at = cyc + ((nres == 0) ? d1 : 2);
        nres++;
      end
      if (DONE) begin
        ndone++;
        t_done = cyc;
        chk($sformatf("%s_done_idx", tag), int'(PATTERN_IDX), 2);
      end
      RX_VALID = (cyc == 3 || cyc == 4);
      RX = (cyc == 3) ? 16'h1005 : 16'h0001;
      TX_ACK = (cyc == ack_at);
      if (cyc == ack_at && nres == 1) begin
        t_ack = cyc;
        chk($sformatf("%s_held_tx", tag), int'(TX_DATA), 24);
      end
      pen = COUNT_EN;
      ptxv = TX_VALID;
    end
    RX_VALID = 1'b0;
    TX_ACK = 1'b0;
    chk($sformatf("%s_ntrig", tag), ntrig, 3);
    chk($sformatf("%s_nres", tag), nres, 3);
    chk($sformatf("%s_ndone", tag), ndone, 1);
    chk($sformatf("%s_busy_end", tag), int'(BUSY), 0);
    chk($sformatf("%s_txv_end", tag), int'(TX_VALID), 0);
  endtask

  initial begin
    int nq;
    tbl[0]  = '{16'h0003, 2'b10, 5'b00000, 12'd0, 17'h00000};
    tbl[1]  = '{16'h1005, 2'b10, 5'b00000, 12'd0, 17'h00000};
    tbl[2]  = '{16'h1000, 2'b10, 5'b00000, 12'd0, 17'h00000};
    tbl[3]  = '{16'h3000, 2'b10, 5'b00000, 12'd0, 17'h00000};
    tbl[4]  = '{16'h2000, 2'b10, 5'b00000, 12'd0, 17'h00000};
    tbl[5]  = '{16'h7001, 2'b10, 5'b00000, 12'd0, 17'h00000};
    tbl[6]  = '{16'h0002, 2'b10, 5'b00000, 12'd0, 17'h00000};
    tbl[7]  = '{16'h0001, 2'b10, 5'b11000, 12'd0, 17'h00000};
    tbl[8]  = '{16'h0000, 2'b00, 5'b10100, 12'd0, 17'h00000};
    tbl[9]  = '{16'h0000, 2'b00, 5'b10100, 12'd0, 17'h00000};
    tbl[10] = '{16'h0000, 2'b00, 5'b10100, 12'd0, 17'h00000};
    tbl[11] = '{16'h0000, 2'b00, 5'b10100, 12'd0, 17'h00000};
    tbl[12] = '{16'h0000, 2'b00, 5'b10000, 12'd0, 17'h00000};
    tbl[13] = '{16'h0000, 2'b00, 5'b10001, 12'd0, 17'h00000};
    tbl[14] = '{16'h0000, 2'b00, 5'b00010, 12'd0, 17'h1000C};
    tbl[15] = '{16'h0000, 2'b01, 5'b00000, 12'd0, 17'h00000};
    tbl[16] = '{16'h0003, 2'b10, 5'b00010, 12'd0, 17'h1000C};
    tbl[17] = '{16'h0000, 2'b01, 5'b00000, 12'd0, 17'h00000};

    RST_N = 1'b0; RX = 16'h0000; RX_VALID = 1'b0; TX_ACK = 1'b0;
    step(2);
    chk("rst_outs", int'({BUSY, PATTERN_TRIG, COUNT_EN, TX_VALID, DONE, COUNT_CLR}), 0);
    chk("rst_tx_data", int'(TX_DATA), 0);
    chk("rst_idx", int'(PATTERN_IDX), 0);
    RST_N = 1'b1;

    // Reset-default config: 1-tick window, no settle, single pattern.
    for (int i = 0; i < 18; i++) begin
      RX = tbl[i].rx;
      RX_VALID = tbl[i].va[1];
      TX_ACK = tbl[i].va[0];
      step(1);
      chk($sformatf("vec%0d_outs", i), int'({BUSY, PATTERN_TRIG, COUNT_EN, TX_VALID, DONE}),
          int'(tbl[i].outs));
      chk($sformatf("vec%0d_idx", i), int'(PATTERN_IDX), int'(tbl[i].idx));
      if (tbl[i].tx[16]) chk($sformatf("vec%0d_tx", i), int'(TX_DATA), int'(tbl[i].tx[15:0]));
    end
    RX_VALID = 1'b0; TX_ACK = 1'b0; RX = 16'h0000;

    send(16'h1002);
    send(16'h2001);
    send(16'h3003);
    run_acq(2, "acq");
    step(2);
    run_acq(50, "stall");
    step(2);

    // Abort mid-GATE of the second pattern.
    send(16'h0001);
    wait_for(1, "ab_wait_res0");
    ack1();
    wait_for(0, "ab_wait_gate1");
    chk("ab_idx_gate", int'(PATTERN_IDX), 1);
    step(2);
    send(16'h0000);
    chk("ab_en", int'(COUNT_EN), 0);
    chk("ab_busy", int'(BUSY), 0);
    chk("ab_txv", int'(TX_VALID), 0);
    chk("ab_idx_held", int'(PATTERN_IDX), 1);
    nq = 0;
    repeat (20) begin
      if (DONE || BUSY || PATTERN_TRIG) nq++;
      step(1);
    end
    chk("ab_quiet", nq, 0);
    send(16'h0001);
    chk("restart_trig", int'(PATTERN_TRIG), 1);
    chk("restart_idx", int'(PATTERN_IDX), 0);

    // Abort while stalled in HOLD with an unread result, then re-present it.
    wait_for(1, "hold_wait_res0");
    step(30);
    chk("hold_state", int'({BUSY, COUNT_EN, TX_VALID}), 3'b101);
    chk("hold_idx", int'(PATTERN_IDX), 1);
    send(16'h0000);
    chk("hold_stop_txv", int'(TX_VALID), 0);
    chk("hold_stop_busy", int'(BUSY), 0);
    chk("hold_stop_tx", int'(TX_DATA), 24);
    send(16'h0003);
    chk("read_txv", int'(TX_VALID), 1);
    chk("read_tx", int'(TX_DATA), 24);
    // Ack coinciding with stop still leaves TX_VALID low.
    RX = 16'h0000; RX_VALID = 1'b1; TX_ACK = 1'b1;
    step(1);
    RX_VALID = 1'b0; TX_ACK = 1'b0;
    chk("stop_ack_txv", int'(TX_VALID), 0);

    // Reset in the middle of a gate window.
    send(16'h0001);
    wait_for(0, "mrst_wait_gate");
    RST_N = 1'b0;
    step(1);
    RST_N = 1'b1;
    chk("mrst_outs", int'({BUSY, PATTERN_TRIG, COUNT_EN, TX_VALID, DONE, COUNT_CLR}), 0);
    chk("mrst_tx_data", int'(TX_DATA), 0);
    chk("mrst_idx", int'(PATTERN_IDX), 0);
    send(16'h0003);
    chk("mrst_read_none", int'(TX_VALID), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
